// File: rtl/uart_byte_tx.sv
// Byte-wide asynchronous UART transmitter: start bit, 8 data bits LSB-first,
// optional odd/even parity, one or two stop bits, then a one-cycle is_done pulse.
module uart_byte_tx #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD      = 9600,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] uart_data,
   input  logic       is_send,
   output logic       txd,
   output logic       is_done,
   output logic       busy
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int CNT_W    = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

   // Parity modes 3+ and stop counts other than 2 fall back to none / one stop.
   localparam bit PAR_EN   = (PARITY == 1) || (PARITY == 2);
   localparam bit PAR_ODD  = (PARITY == 1);
   localparam bit TWO_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_DONE
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             par_bit;
   logic             stop_idx;
   logic             cell_end;

   assign cell_end = (baud_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         stop_idx <= 1'b0;
         txd      <= 1'b1;
         is_done  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         is_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               txd  <= 1'b1;
               busy <= 1'b0;
               if (is_send) begin
                  shift    <= uart_data;
                  par_bit  <= PAR_ODD ? ~^uart_data : ^uart_data;
                  baud_cnt <= '0;
                  state    <= ST_START;
                  txd      <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            ST_START: begin
               if (cell_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= ST_DATA;
                  txd      <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            // txd is registered, so the next bit is taken from shift[1] before the shift lands.
            ST_DATA: begin
               if (cell_end) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  if (bit_idx == 3'd7) begin
                     if (PAR_EN) begin
                        state <= ST_PARITY;
                        txd   <= par_bit;
                     end else begin
                        state    <= ST_STOP;
                        stop_idx <= 1'b0;
                        txd      <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            ST_PARITY: begin
               if (cell_end) begin
                  baud_cnt <= '0;
                  state    <= ST_STOP;
                  stop_idx <= 1'b0;
                  txd      <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            ST_STOP: begin
               txd <= 1'b1;
               if (cell_end) begin
                  baud_cnt <= '0;
                  if (stop_idx == TWO_STOP) begin
                     state   <= ST_DONE;
                     is_done <= 1'b1;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            // is_send is deliberately ignored here while upstream drops it.
            ST_DONE: begin
               state <= ST_IDLE;
               txd   <= 1'b1;
               busy  <= 1'b0;
            end

            default: begin
               state <= ST_IDLE;
               txd   <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: four instances (no parity, odd, even, even + 2 stop)
// checked every cycle against a queue-based frame model plus literal expectations.
module tb_uart_byte_tx;

   localparam int DIV = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_w [4];
   logic       send_w [4];
   logic       txd_w  [4];
   logic       done_w [4];
   logic       busy_w [4];

   always #5 clk = ~clk;

   uart_byte_tx #(.CLK_FREQ(1000), .BAUD(100), .PARITY(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .uart_data(data_w[0]), .is_send(send_w[0]),
      .txd(txd_w[0]), .is_done(done_w[0]), .busy(busy_w[0]));
   uart_byte_tx #(.CLK_FREQ(1000), .BAUD(100), .PARITY(1), .STOP_BITS(1)) u1 (
      .clk(clk), .rst(rst), .uart_data(data_w[1]), .is_send(send_w[1]),
      .txd(txd_w[1]), .is_done(done_w[1]), .busy(busy_w[1]));
   uart_byte_tx #(.CLK_FREQ(1000), .BAUD(100), .PARITY(2), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .uart_data(data_w[2]), .is_send(send_w[2]),
      .txd(txd_w[2]), .is_done(done_w[2]), .busy(busy_w[2]));
   uart_byte_tx #(.CLK_FREQ(1000), .BAUD(100), .PARITY(2), .STOP_BITS(2)) u3 (
      .clk(clk), .rst(rst), .uart_data(data_w[3]), .is_send(send_w[3]),
      .txd(txd_w[3]), .is_done(done_w[3]), .busy(busy_w[3]));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int done_cnt [4];
   int t_start;
   int t_done;

   function automatic int par_of(input int k);
      return (k == 0) ? 0 : (k == 1) ? 1 : 2;
   endfunction

   function automatic int stop_of(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   function automatic int frame_cells(input int k);
      return 10 + ((par_of(k) != 0) ? 1 : 0) + stop_of(k) - 1;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: one {txd,busy,is_done} entry per clock after each edge.
   logic [2:0] exp_q [4][$];
   logic       cool  [4];
   logic [2:0] exp_v [4];

   task automatic push_frame(input int k, input logic [7:0] b);
      logic cv [$];
      int   ones;
      cv.push_back(1'b0);
      for (int i = 0; i < 8; i++) cv.push_back(b[i]);
      if (par_of(k) != 0) begin
         ones = $countones(b);
         if (par_of(k) == 1) cv.push_back((ones % 2) == 0);
         else cv.push_back((ones % 2) == 1);
      end
      for (int i = 0; i < stop_of(k); i++) cv.push_back(1'b1);
      foreach (cv[i]) for (int j = 0; j < DIV; j++) exp_q[k].push_back({cv[i], 1'b1, 1'b0});
      exp_q[k].push_back(3'b111);
   endtask

   always @(posedge clk) begin
      cyc++;
      for (int k = 0; k < 4; k++) begin
         if (rst) begin
            exp_q[k].delete();
            cool[k]  = 1'b0;
            exp_v[k] = 3'b100;
         end else if (exp_q[k].size() > 0) begin
            exp_v[k] = exp_q[k].pop_front();
            cool[k]  = exp_v[k][0];
         end else if (cool[k]) begin
            cool[k]  = 1'b0;
            exp_v[k] = 3'b100;
         end else if (send_w[k]) begin
            push_frame(k, data_w[k]);
            exp_v[k] = exp_q[k].pop_front();
         end else begin
            exp_v[k] = 3'b100;
         end
      end
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("model_u%0d_txd_busy_done", k), {txd_w[k], busy_w[k], done_w[k]}, exp_v[k]);
         if (done_w[k]) done_cnt[k]++;
      end
   end

   // Upstream driver: raise is_send, sample mid-cell, drop is_send on is_done.
   task automatic run_frame(input int k, input logic [7:0] b, input int chg_at, input int rst_at,
                            output logic [15:0] cells, output int lat);
      int n;
      bit got;
      cells = '0;
      lat   = -1;
      got   = 1'b0;
      data_w[k] = b;
      send_w[k] = 1'b1;
      @(posedge clk); #2;
      n = 0;
      t_start = cyc;
      check($sformatf("model_len_u%0d", k), exp_q[k].size(), frame_cells(k) * DIV);
      while (!got && n < 400) begin
         if ((n % DIV) == 5 && (n / DIV) < 16) cells[n / DIV] = txd_w[k];
         if (n == chg_at) data_w[k] = 8'hFF;
         if (n == rst_at) begin
            rst = 1'b1;
            send_w[k] = 1'b0;
            @(posedge clk); #2;
            check("abort_txd", txd_w[k], 1);
            check("abort_busy", busy_w[k], 0);
            repeat (2) @(posedge clk);
            #2;
            rst = 1'b0;
            lat = -2;
            return;
         end
         if (done_w[k]) begin
            got = 1'b1;
            lat = n;
            t_done = cyc;
            send_w[k] = 1'b0;
         end else begin
            @(posedge clk); #2;
            n++;
         end
      end
      if (!got) begin
         check($sformatf("timeout_u%0d", k), 0, 1);
         send_w[k] = 1'b0;
         return;
      end
      @(posedge clk); #2;
      check($sformatf("busy_fall_u%0d", k), busy_w[k], 0);
      check($sformatf("done_single_u%0d", k), done_w[k], 0);
   endtask

   logic [15:0] cells;
   int          lat;
   int          d0;
   int          prev_done;
   logic [7:0]  seq [4];

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         send_w[k] = 1'b0;
         data_w[k] = 8'h00;
         done_cnt[k] = 0;
      end
      seq[0] = 8'h0F; seq[1] = 8'h18; seq[2] = 8'h37; seq[3] = 8'hFE;

      repeat (3) @(posedge clk);
      #2;
      for (int k = 0; k < 4; k++) check("reset_outputs", {txd_w[k], busy_w[k], done_w[k]}, 3'b100);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("idle_outputs", {txd_w[0], busy_w[0], done_w[0]}, 3'b100);

      d0 = done_cnt[0];
      run_frame(0, 8'hA5, -1, -1, cells, lat);
      check("a5_latency", lat, 100);
      check("a5_cells", int'(cells[9:0]), 10'b1101001010);
      check("a5_done_pulses", done_cnt[0] - d0, 1);

      run_frame(1, 8'h0F, -1, -1, cells, lat);
      check("odd_latency", lat, 110);
      check("odd_parity_cell", cells[9], 1);
      check("odd_byte", int'(cells[8:1]), 8'h0F);
      run_frame(2, 8'h0F, -1, -1, cells, lat);
      check("even_latency", lat, 110);
      check("even_parity_cell", cells[9], 0);
      run_frame(3, 8'h0F, -1, -1, cells, lat);
      check("stop2_latency", lat, 120);
      check("stop2_parity_cell", cells[9], 0);
      check("stop2_stop_cells", int'(cells[11:10]), 2'b11);

      repeat (3) @(posedge clk);
      #2;
      d0 = done_cnt[0];
      prev_done = -1;
      for (int i = 0; i < 4; i++) begin
         run_frame(0, seq[i], -1, -1, cells, lat);
         check($sformatf("seq_byte%0d", i), int'(cells[8:1]), seq[i]);
         check($sformatf("seq_latency%0d", i), lat, 100);
         if (i > 0) check($sformatf("seq_gap%0d", i), t_start - prev_done, 2);
         prev_done = t_done;
      end
      repeat (30) @(posedge clk);
      #2;
      check("seq_done_pulses", done_cnt[0] - d0, 4);

      run_frame(0, 8'h3C, 35, -1, cells, lat);
      check("late_data_byte", int'(cells[8:1]), 8'h3C);

      d0 = done_cnt[0];
      run_frame(0, 8'h5A, -1, 47, cells, lat);
      check("abort_no_done", done_cnt[0] - d0, 0);
      run_frame(0, 8'h5A, -1, -1, cells, lat);
      check("fresh_byte", int'(cells[8:1]), 8'h5A);
      check("fresh_latency", lat, 100);
      check("fresh_done_pulses", done_cnt[0] - d0, 1);

      repeat (5) @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
